mips_debug_host: RTL

//  Host-side master for the mips core's debug port (debug_en/debug_step/debug_addr/debug_data).

---
 rtl/mips_debug_host_pkg.sv | 29 ++
 rtl/mips_debug_host_if.sv | 44 ++++
 rtl/mips_debug_host_step_pulser.sv | 81 ++++++++
 rtl/mips_debug_host.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/mips_debug_host_pkg.sv
// Shared definitions for the mips debug host.
//  - command opcode encodings presented on cmd_op
//  - debug address / data widths of the mips debug port
//  - counter widths and the load helpers that map a count of 0 to the maximum
package mips_debug_host_pkg;

    localparam int DEBUG_ADDR_W = 7;
    localparam int DATA_W       = 32;
    localparam int WORD_CNT_W   = 8;
    localparam int STEP_CNT_W   = 9;

    typedef enum logic [1:0] {
        OP_RUN  = 2'd0,
        OP_HALT = 2'd1,
        OP_STEP = 2'd2,
        OP_DUMP = 2'd3
    } cmd_op_t;

    // A DUMP count of 0 means a full sweep of the 128-entry debug space.
    function automatic logic [WORD_CNT_W-1:0] word_load(input logic [7:0] count);
        return (count == 8'd0) ? 8'd128 : count;
    endfunction

    // A STEP count of 0 means 256 steps, hence the extra counter bit.
    function automatic logic [STEP_CNT_W-1:0] step_load(input logic [7:0] count);
        return (count == 8'd0) ? 9'd256 : {1'b0, count};
    endfunction

endpackage

// File: rtl/mips_debug_host_if.sv
// Bus bundle for the mips debug host.
//  Command channel : cmd_valid/cmd_ready/cmd_op/cmd_base/cmd_count
//  Core debug port : debug_en/debug_step/debug_addr (to core), debug_data (from core)
//  Output stream   : out_valid/out_ready/out_addr/out_data/out_last
//  Status          : busy
// Handshakes (command and output stream): a transfer happens on a rising clk edge
// where valid and ready are both high; the sender holds its payload stable and
// keeps valid high until that edge, and ready may change freely.
// master = the debug host, slave = its environment (command source, core, consumer).
interface mips_debug_host_if;
    import mips_debug_host_pkg::*;

    logic                    cmd_valid;
    logic                    cmd_ready;
    cmd_op_t                 cmd_op;
    logic [DEBUG_ADDR_W-1:0] cmd_base;
    logic [7:0]              cmd_count;

    logic                    debug_en;
    logic                    debug_step;
    logic [DEBUG_ADDR_W-1:0] debug_addr;
    logic [DATA_W-1:0]       debug_data;

    logic                    out_valid;
    logic                    out_ready;
    logic [DEBUG_ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0]       out_data;
    logic                    out_last;

    logic                    busy;

    modport master (
        input  cmd_valid, cmd_op, cmd_base, cmd_count, debug_data, out_ready,
        output cmd_ready, debug_en, debug_step, debug_addr,
               out_valid, out_addr, out_data, out_last, busy
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_base, cmd_count, debug_data, out_ready,
        input  cmd_ready, debug_en, debug_step, debug_addr,
               out_valid, out_addr, out_data, out_last, busy
    );

endinterface

// File: rtl/mips_debug_host_step_pulser.sv
// Single-step pulse generator.
//  i_start  : begin a pulse (accepted when idle, or on the o_done cycle to chain pulses)
//  o_step   : registered step pulse, high STEP_HIGH cycles then low STEP_GAP cycles
//  o_hi_end : last high cycle of the current pulse
//  o_done   : last low cycle of the gap; a start here re-arms without an extra idle cycle
//  o_state  : internal phase for observation
module mips_debug_host_step_pulser #(
    parameter int STEP_HIGH = 4,
    parameter int STEP_GAP  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_start,
    output logic       o_step,
    output logic       o_hi_end,
    output logic       o_done,
    output logic [1:0] o_state
);

    localparam int CNT_MAX = (STEP_HIGH > STEP_GAP) ? STEP_HIGH : STEP_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] HI_LOAD = CNT_W'(STEP_HIGH - 1);
    localparam logic [CNT_W-1:0] LO_LOAD = CNT_W'(STEP_GAP - 1);

    typedef enum logic [1:0] {
        P_IDLE = 2'd0,
        P_HI   = 2'd1,
        P_LO   = 2'd2
    } pstate_t;

    pstate_t          r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_step;

    assign o_step   = r_step;
    assign o_hi_end = (r_state == P_HI) && (r_cnt == '0);
    assign o_done   = (r_state == P_LO) && (r_cnt == '0);
    assign o_state  = r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= P_IDLE;
            r_cnt   <= '0;
            r_step  <= 1'b0;
        end else begin
            case (r_state)
                P_IDLE: begin
                    if (i_start) begin
                        r_step  <= 1'b1;
                        r_cnt   <= HI_LOAD;
                        r_state <= P_HI;
                    end
                end
                P_HI: begin
                    if (r_cnt == '0) begin
                        r_step  <= 1'b0;
                        r_cnt   <= LO_LOAD;
                        r_state <= P_LO;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                P_LO: begin
                    if (r_cnt == '0) begin
                        if (i_start) begin
                            r_step  <= 1'b1;
                            r_cnt   <= HI_LOAD;
                            r_state <= P_HI;
                        end else begin
                            r_state <= P_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: r_state <= P_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/mips_debug_host.sv
// Host-side master for the mips core debug port.
// Accepts RUN/HALT/STEP/DUMP commands, halts/resumes and single-steps the core,
// and sweeps debug addresses, streaming each captured word with its address.
//  clk, rst_n    : clock, asynchronous active-low reset
//  bus (master)  : command channel, core debug port, output stream, busy
//  o_state       : main FSM state (IDLE=0 STEP_HI=1 STEP_LO=2 RD_WAIT=3 RD_OUT=4)
//  o_pulse_state : step pulser phase
module mips_debug_host
    import mips_debug_host_pkg::*;
#(
    parameter int READ_LAT  = 2,
    parameter int STEP_HIGH = 4,
    parameter int STEP_GAP  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    mips_debug_host_if.master  bus,
    output logic [2:0]         o_state,
    output logic [1:0]         o_pulse_state
);

    localparam int LAT_W = $clog2(READ_LAT + 1);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(READ_LAT);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_STEP_HI = 3'd1,
        S_STEP_LO = 3'd2,
        S_RD_WAIT = 3'd3,
        S_RD_OUT  = 3'd4
    } state_t;

    state_t                  r_state;
    logic [STEP_CNT_W-1:0]   r_step_cnt;
    logic [WORD_CNT_W-1:0]   r_words;
    logic [LAT_W-1:0]        r_lat;
    logic                    r_debug_en;
    logic [DEBUG_ADDR_W-1:0] r_debug_addr;
    logic                    r_out_valid;
    logic [DEBUG_ADDR_W-1:0] r_out_addr;
    logic [DATA_W-1:0]       r_out_data;
    logic                    r_out_last;

    logic w_accept;
    logic w_pulse_start;
    logic w_step;
    logic w_hi_end;
    logic w_done;

    assign w_accept = (r_state == S_IDLE) && bus.cmd_valid;

    // A new pulse starts on a STEP accept, or back-to-back from the end of the
    // previous gap while more steps remain, so the gap is exactly STEP_GAP.
    assign w_pulse_start = (w_accept && (bus.cmd_op == OP_STEP)) ||
                           ((r_state == S_STEP_LO) && w_done && (r_step_cnt != 9'd1));

    mips_debug_host_step_pulser #(
        .STEP_HIGH (STEP_HIGH),
        .STEP_GAP  (STEP_GAP)
    ) u_pulser (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (w_pulse_start),
        .o_step   (w_step),
        .o_hi_end (w_hi_end),
        .o_done   (w_done),
        .o_state  (o_pulse_state)
    );

    assign bus.cmd_ready  = (r_state == S_IDLE);
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.debug_en   = r_debug_en;
    assign bus.debug_step = w_step;
    assign bus.debug_addr = r_debug_addr;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_addr   = r_out_addr;
    assign bus.out_data   = r_out_data;
    assign bus.out_last   = r_out_last;
    assign o_state        = r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_step_cnt   <= '0;
            r_words      <= '0;
            r_lat        <= '0;
            r_debug_en   <= 1'b0;
            r_debug_addr <= '0;
            r_out_valid  <= 1'b0;
            r_out_addr   <= '0;
            r_out_data   <= '0;
            r_out_last   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        case (bus.cmd_op)
                            OP_RUN:  r_debug_en <= 1'b0;
                            OP_HALT: r_debug_en <= 1'b1;
                            OP_STEP: begin
                                r_debug_en <= 1'b1;
                                r_step_cnt <= step_load(bus.cmd_count);
                                r_state    <= S_STEP_HI;
                            end
                            OP_DUMP: begin
                                r_debug_addr <= bus.cmd_base;
                                r_words      <= word_load(bus.cmd_count);
                                r_lat        <= LAT_LOAD;
                                r_state      <= S_RD_WAIT;
                            end
                            default: r_state <= S_IDLE;
                        endcase
                    end
                end
                S_STEP_HI: begin
                    if (w_hi_end) r_state <= S_STEP_LO;
                end
                S_STEP_LO: begin
                    if (w_done) begin
                        r_step_cnt <= r_step_cnt - 9'd1;
                        r_state    <= (r_step_cnt == 9'd1) ? S_IDLE : S_STEP_HI;
                    end
                end
                S_RD_WAIT: begin
                    // r_lat was loaded on the address update; sampling when it
                    // reaches 1 gives exactly READ_LAT cycles of settling.
                    if (r_lat == LAT_W'(1)) begin
                        r_out_data  <= bus.debug_data;
                        r_out_addr  <= r_debug_addr;
                        r_out_last  <= (r_words == 8'd1);
                        r_out_valid <= 1'b1;
                        r_state     <= S_RD_OUT;
                    end else begin
                        r_lat <= r_lat - LAT_W'(1);
                    end
                end
                S_RD_OUT: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_words     <= r_words - 8'd1;
                        if (r_out_last) begin
                            r_out_last <= 1'b0;
                            r_state    <= S_IDLE;
                        end else begin
                            r_debug_addr <= r_debug_addr + 7'd1;
                            r_lat        <= LAT_LOAD;
                            r_state      <= S_RD_WAIT;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
